// File: rtl/wb_spi_slave_pkg.sv
// Shared definitions for the Wishbone SPI slave: register offsets, STAT bit
// positions and the SPI engine state type.
package wb_spi_slave_pkg;

  localparam logic [3:0] REG_DATA = 4'd0;
  localparam logic [3:0] REG_STAT = 4'd1;
  localparam logic [3:0] REG_IEN  = 4'd2;

  localparam int STAT_RX_AVAIL  = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_UNDERRUN  = 4;
  localparam int STAT_CS_ACTIVE = 5;

  typedef enum logic [0:0] {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_fifo.sv
// Synchronous 8-bit receive FIFO. A push while full is accepted when a pop
// happens in the same cycle.
module spi_slave_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                  DEPTH_I  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH_I);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            mem_r [0:DEPTH_I-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_I; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_spi_slave.sv
// SPI slave (mode 0, MSB first, 8-bit frames) behind a Wishbone register
// interface; SPI pins are oversampled by clk through 3-stage synchronisers.
module wb_spi_slave
  import wb_spi_slave_pkg::*;
#(
  parameter int         RX_DEPTH_LOG2 = 2,
  parameter logic [7:0] IDLE_BYTE     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  logic [2:0] sck_sync_r, cs_sync_r, mosi_sync_r;
  logic       sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, mosi_s, cs_active_s;

  spi_state_e state_r, state_n;
  logic [2:0] bitcnt_r, bitcnt_n;
  logic [7:0] rx_shift_r, rx_shift_n, tx_shift_r, tx_shift_n, tx_load_val_s;
  logic       reload_r, reload_n, oe_r, oe_n, tx_load_s;

  logic [7:0]  tx_hold_r, tx_hold_n;
  logic        tx_full_r, tx_full_n, underrun_r, underrun_n, overrun_r, overrun_n;
  logic [4:0]  ien_r, ien_n;
  logic [31:0] dat_o_r, dat_o_n;
  logic        ack_r, irq_r;

  logic       bus_fire_s, wr_fire_s, rd_fire_s;
  logic [3:0] reg_sel_s;
  logic       fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0] fifo_head_s;
  logic [RX_DEPTH_LOG2:0] fifo_count_s;
  logic [5:0] stat_s;
  logic       unused_s;

  assign sck_rise_s  =  sck_sync_r[1] & ~sck_sync_r[2];
  assign sck_fall_s  = ~sck_sync_r[1] &  sck_sync_r[2];
  assign cs_fall_s   = ~cs_sync_r[1]  &  cs_sync_r[2];
  assign cs_rise_s   =  cs_sync_r[1]  & ~cs_sync_r[2];
  assign mosi_s      =  mosi_sync_r[1];
  assign cs_active_s = ~cs_sync_r[1];

  assign bus_fire_s = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_fire_s  = bus_fire_s &  wb_we_i;
  assign rd_fire_s  = bus_fire_s & ~wb_we_i;
  assign reg_sel_s  = wb_adr_i[5:2];
  assign fifo_pop_s = rd_fire_s & (reg_sel_s == REG_DATA) & ~fifo_empty_s;

  assign tx_load_val_s = tx_full_r ? tx_hold_r : IDLE_BYTE;
  assign stat_s = {cs_active_s, underrun_r, overrun_r, ~tx_full_r, fifo_full_s, ~fifo_empty_s};
  assign unused_s = &{1'b0, wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:8], fifo_count_s};

  spi_slave_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data ({rx_shift_r[6:0], mosi_s}),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Pin synchronisers; CS idles high so reset does not fake a deselect edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b111;
      mosi_sync_r <= 3'b000;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi_sck};
      cs_sync_r   <= {cs_sync_r[1:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[1:0], spi_mosi};
    end
  end

  // SPI engine next state: framing, shifting and byte-complete push.
  always_comb begin
    state_n     = state_r;
    bitcnt_n    = bitcnt_r;
    rx_shift_n  = rx_shift_r;
    tx_shift_n  = tx_shift_r;
    reload_n    = reload_r;
    oe_n        = oe_r;
    tx_load_s   = 1'b0;
    fifo_push_s = 1'b0;
    case (state_r)
      SPI_IDLE: begin
        if (cs_fall_s) begin
          state_n    = SPI_ACTIVE;
          bitcnt_n   = 3'd0;
          oe_n       = 1'b1;
          reload_n   = 1'b0;
          tx_load_s  = 1'b1;
          tx_shift_n = tx_load_val_s;
        end else begin
          state_n = SPI_IDLE;
        end
      end
      SPI_ACTIVE: begin
        if (cs_rise_s) begin
          state_n    = SPI_IDLE;
          bitcnt_n   = 3'd0;
          oe_n       = 1'b0;
          reload_n   = 1'b0;
          tx_shift_n = 8'h00;
        end else if (sck_rise_s) begin
          rx_shift_n = {rx_shift_r[6:0], mosi_s};
          bitcnt_n   = bitcnt_r + 3'd1;
          if (bitcnt_r == 3'd7) begin
            fifo_push_s = 1'b1;
            reload_n    = 1'b1;
          end else begin
            reload_n = reload_r;
          end
        end else if (sck_fall_s) begin
          if (reload_r) begin
            tx_load_s  = 1'b1;
            reload_n   = 1'b0;
            tx_shift_n = tx_load_val_s;
          end else begin
            tx_shift_n = {tx_shift_r[6:0], 1'b0};
          end
        end else begin
          state_n = SPI_ACTIVE;
        end
      end
      default: begin
        state_n    = SPI_IDLE;
        oe_n       = 1'b0;
        tx_shift_n = 8'h00;
      end
    endcase
  end

  // Register-file next state; sets take priority over W1C, writes over reloads.
  always_comb begin
    tx_hold_n  = tx_hold_r;
    tx_full_n  = tx_full_r;
    ien_n      = ien_r;
    dat_o_n    = dat_o_r;
    underrun_n = (underrun_r & ~(wr_fire_s & (reg_sel_s == REG_STAT) & wb_dat_i[STAT_UNDERRUN]))
               | (tx_load_s & ~tx_full_r);
    overrun_n  = (overrun_r & ~(wr_fire_s & (reg_sel_s == REG_STAT) & wb_dat_i[STAT_OVERRUN]))
               | (fifo_push_s & fifo_full_s & ~fifo_pop_s);
    if (tx_load_s) begin
      tx_full_n = 1'b0;
    end else begin
      tx_full_n = tx_full_r;
    end
    if (wr_fire_s) begin
      case (reg_sel_s)
        REG_DATA: begin
          tx_hold_n = wb_dat_i[7:0];
          tx_full_n = 1'b1;
        end
        REG_IEN: ien_n = wb_dat_i[4:0];
        default: ien_n = ien_r;
      endcase
    end else begin
      ien_n = ien_r;
    end
    if (rd_fire_s) begin
      case (reg_sel_s)
        REG_DATA: dat_o_n = fifo_empty_s ? 32'd0 : {24'd0, fifo_head_s};
        REG_STAT: dat_o_n = {26'd0, stat_s};
        REG_IEN:  dat_o_n = {27'd0, ien_r};
        default:  dat_o_n = 32'd0;
      endcase
    end else begin
      dat_o_n = dat_o_r;
    end
  end

  // State registers for the SPI engine, register file and bus handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= SPI_IDLE;
      bitcnt_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      tx_shift_r <= 8'h00;
      reload_r   <= 1'b0;
      oe_r       <= 1'b0;
      tx_hold_r  <= 8'h00;
      tx_full_r  <= 1'b0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
      ien_r      <= 5'd0;
      dat_o_r    <= 32'd0;
      ack_r      <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      bitcnt_r   <= bitcnt_n;
      rx_shift_r <= rx_shift_n;
      tx_shift_r <= tx_shift_n;
      reload_r   <= reload_n;
      oe_r       <= oe_n;
      tx_hold_r  <= tx_hold_n;
      tx_full_r  <= tx_full_n;
      underrun_r <= underrun_n;
      overrun_r  <= overrun_n;
      ien_r      <= ien_n;
      dat_o_r    <= dat_o_n;
      ack_r      <= wb_stb_i & wb_cyc_i;
      irq_r      <= |(stat_s[4:0] & ien_r);
    end
  end

  assign wb_dat_o    = dat_o_r;
  assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_r;
  assign spi_miso    = tx_shift_r[7];
  assign spi_miso_oe = oe_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Scoreboard bench for wb_spi_slave: stimulus pushes expected bus reads and
// MISO bytes from a queue-based model; monitors pop and compare.
module tb_wb_spi_slave;
  import wb_spi_slave_pkg::*;

  localparam int HALF = 80;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] wb_adr_i = 32'd0, wb_dat_i = 32'd0, wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  always #5 clk = ~clk;

  wb_spi_slave dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  int total = 0, bad = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  miso_exp_q[$];

  // reference model state
  logic [7:0] rx_m[$];
  logic [7:0] hold_m, next_miso_m;
  bit         hold_full_m, underrun_m, overrun_m;
  logic [4:0] ien_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    rx_m.delete();
    hold_m = 8'h00; hold_full_m = 1'b0; underrun_m = 1'b0; overrun_m = 1'b0;
    ien_m = 5'd0; next_miso_m = 8'h00;
  endfunction

  // byte the slave will shift out next: holding register if loaded, else idle byte
  function automatic logic [7:0] tx_source();
    if (hold_full_m) begin
      hold_full_m = 1'b0;
      return hold_m;
    end
    underrun_m = 1'b1;
    return 8'hFF;
  endfunction

  function automatic logic [5:0] stat_m();
    return {1'b0, underrun_m, overrun_m, ~hold_full_m, rx_m.size() == 4, rx_m.size() != 0};
  endfunction

  // raw bus access; called at a negedge, returns at a negedge
  task automatic bus_xfer(input bit we, input logic [3:0] r, input logic [31:0] d);
    bit ok = 1'b0;
    wb_adr_i = {26'd0, r, 2'b00}; wb_dat_i = d; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bus_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] r, input logic [31:0] d);
    case (r)
      REG_DATA: begin hold_m = d[7:0]; hold_full_m = 1'b1; end
      REG_STAT: begin
        if (d[3]) overrun_m = 1'b0;
        if (d[4]) underrun_m = 1'b0;
      end
      REG_IEN: ien_m = d[4:0];
      default: ;
    endcase
    bus_xfer(1'b1, r, d);
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] r);
    case (r)
      REG_DATA: return (rx_m.size() != 0) ? {24'd0, rx_m.pop_front()} : 32'd0;
      REG_STAT: return {26'd0, stat_m()};
      REG_IEN:  return {27'd0, ien_m};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic do_read(input logic [3:0] r);
    rd_exp_q.push_back(exp_read(r));
    bus_xfer(1'b0, r, 32'd0);
  endtask

  task automatic chk_irq(input string name);
    logic [5:0] s;
    repeat (3) @(negedge clk);
    s = stat_m();
    chk(name, {31'd0, irq}, {31'd0, |(s[4:0] & ien_m)});
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    next_miso_m = tx_source();
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  // clocks nbits of d; rd_sync lines a DATA read up with the byte-complete push
  task automatic host_byte(input logic [7:0] d, input int nbits, input bit rd_sync);
    if (nbits == 8) miso_exp_q.push_back(next_miso_m);
    if (rd_sync) rd_exp_q.push_back(exp_read(REG_DATA));
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = d[7-i];
      #HALF;
      if (rd_sync && i == 7) begin
        fork
          begin spi_sck = 1'b1; #HALF; end
          begin #20; bus_xfer(1'b0, REG_DATA, 32'd0); end
        join
      end else begin
        spi_sck = 1'b1;
        #HALF;
      end
      spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      if (rx_m.size() < 4) rx_m.push_back(d);
      else overrun_m = 1'b1;
      next_miso_m = tx_source();
    end
  endtask

  // bus read monitor
  always @(negedge clk) begin
    if (wb_ack_o && !wb_we_i) begin
      if (rd_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_read_unexpected: got %h expected none", wb_dat_o);
      end else begin
        chk("wb_read", wb_dat_o, rd_exp_q.pop_front());
      end
    end
  end

  // MISO monitor: collects whole bytes as the host would
  logic [7:0] mbits = 8'h00;
  int         mcnt = 0;
  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      mcnt = 0;
    end else begin
      mbits = {mbits[6:0], spi_miso};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (miso_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL miso_unexpected: got %h expected none", mbits);
        end else begin
          chk("miso_byte", {24'd0, mbits}, {24'd0, miso_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // reset in the middle of a frame
    do_write(REG_DATA, 32'h80);
    cs_low();
    host_byte(8'($urandom), 3, 1'b0);
    chk("oe_mid_frame", {31'd0, spi_miso_oe}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    spi_cs_n = 1'b1; spi_sck = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_read(REG_STAT);
    do_read(REG_DATA);

    // one byte each way
    do_write(REG_DATA, 32'hA5);
    cs_low(); host_byte(8'h3C, 8, 1'b0); cs_high();
    do_read(REG_DATA);
    do_read(REG_STAT);

    // underrun then W1C
    cs_low(); host_byte(8'($urandom), 8, 1'b0); host_byte(8'($urandom), 8, 1'b0); cs_high();
    do_read(REG_STAT);
    do_write(REG_STAT, 32'h10);
    do_read(REG_STAT);
    do_read(REG_DATA); do_read(REG_DATA);

    // overrun with irq on overrun only
    do_write(REG_IEN, 32'h08);
    chk_irq("irq_before_overrun");
    cs_low();
    for (int i = 1; i <= 5; i++) host_byte(8'(i), 8, 1'b0);
    cs_high();
    chk_irq("irq_overrun");
    for (int i = 0; i < 4; i++) do_read(REG_DATA);
    do_read(REG_STAT);
    do_write(REG_STAT, 32'h18);
    chk_irq("irq_cleared");

    // aborted partial byte
    cs_low(); host_byte(8'hF0, 5, 1'b0); cs_high();
    do_read(REG_STAT);
    cs_low(); host_byte(8'h81, 8, 1'b0); cs_high();
    do_read(REG_DATA);

    // pop and push in the same cycle at full
    do_write(REG_STAT, 32'h18);
    cs_low();
    for (int i = 0; i < 4; i++) host_byte(8'($urandom), 8, 1'b0);
    cs_high();
    cs_low(); host_byte(8'($urandom), 8, 1'b1); cs_high();
    do_read(REG_STAT);
    for (int i = 0; i < 4; i++) do_read(REG_DATA);

    // randomised mix
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 6))
        0: do_write(REG_DATA, $urandom);
        1: do_read(REG_DATA);
        2: do_read(REG_STAT);
        3: begin
          int nb = $urandom_range(1, 3);
          cs_low();
          for (int k = 0; k < nb; k++) host_byte(8'($urandom), 8, 1'b0);
          cs_high();
        end
        4: do_write(REG_STAT, $urandom);
        5: do_write(REG_IEN, $urandom);
        default: begin
          if ($urandom_range(0, 1) == 0) do_read(4'($urandom_range(0, 15)));
          else do_write(4'($urandom_range(3, 15)), $urandom);
        end
      endcase
      chk_irq("irq_random");
    end

    repeat (10) @(negedge clk);
    chk("miso_queue_drained", miso_exp_q.size(), 32'd0);
    chk("read_queue_drained", rd_exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
